fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: credit-limited request issue, in-order response queue,
// and a FLUSH state that drains stale responses after a redirect.
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [31:0]        buf_instr_q [DEPTH];
    logic [31:0]        buf_instr_d [DEPTH];
    logic [31:0]        buf_pc_q    [DEPTH];
    logic [31:0]        buf_pc_d    [DEPTH];

    logic               credit_ok;
    logic               req_fire;
    logic               rsp_take;
    logic               push;
    logic               pop;
    logic [31:0]        redirect_pc_al;
    logic               unused_redirect_lsb;

    // Handshake qualifiers and head-of-queue outputs
    always_comb begin
        credit_ok           = (SUM_W'(count_q) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);
        mem_req_valid       = rst && (state_q == ST_RUN) && !redirect && credit_ok;
        mem_req_addr        = fetch_pc_q;
        instr_valid         = rst && (state_q == ST_RUN) && (count_q != '0);
        instr               = buf_instr_q[head_q];
        instr_pc            = buf_pc_q[head_q];
        instr_pcplus4       = buf_pc_q[head_q] + 32'd4;
        req_fire            = mem_req_valid && mem_req_ready;
        rsp_take            = mem_rsp_valid && (outstanding_q != '0);
        push                = rsp_take && (state_q == ST_RUN) && !redirect;
        pop                 = instr_valid && instr_ready && !redirect;
        redirect_pc_al      = {redirect_pc[31:2], 2'b00};
        unused_redirect_lsb = ^redirect_pc[1:0];
    end

    // Next-state: queue bookkeeping, then redirect overrides everything
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            buf_instr_d[tail_q] = mem_rsp_data;
            buf_pc_d[tail_q]    = rsp_pc_q;
            tail_d              = tail_q + PTR_W'(1);
            rsp_pc_d            = rsp_pc_q + 32'd4;
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        if (redirect) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = redirect_pc_al;
            rsp_pc_d   = redirect_pc_al;
            state_d    = (outstanding_d != '0) ? ST_FLUSH : ST_RUN;
        end else if ((state_q == ST_FLUSH) && (outstanding_d == '0)) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            buf_instr_q   <= '{default: '0};
            buf_pc_q      <= '{default: '0};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

endmodule
